// File: rtl/uart_core.sv
// ---------------------------------------------------------------------------
// uart_core
//   Full-duplex UART. It has one oversampling tick generator that the
//   transmitter and the receiver share. Otherwise the transmitter and the
//   receiver are independent state machines.
//
//   Parameters
//     CLK_FREQ    system clock in Hz
//     BAUD_RATE   line rate in bit/s
//     OVERSAMPLE  sample ticks per bit (even, 8..32)
//     DATA_BITS   payload width (5..9)
//     PARITY      0 none, 1 even, 2 odd
//     STOP_BITS   1 or 2 (the receiver checks only the first one)
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     tx_valid/tx_ready transmit handshake; tx_data captured on transfer
//     tx                serial output, idles high
//     rx                asynchronous serial input
//     rx_valid/rx_ready receive handshake; rx_data and flags held until accept
//     rx_frame_err      first stop bit voted low
//     rx_parity_err     parity mismatch (only when PARITY != 0)
//     rx_overrun        sticky; a completed frame was dropped while rx_valid=1
// ---------------------------------------------------------------------------
module uart_core #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx,
   input  logic                 rx,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   // Phase positions within one bit (counts 0..OVERSAMPLE-1)
   localparam logic [4:0] OS_LAST = 5'(OVERSAMPLE - 1);
   localparam logic [4:0] OS_S0   = 5'(OVERSAMPLE / 2 - 1);
   localparam logic [4:0] OS_S1   = 5'(OVERSAMPLE / 2);
   localparam logic [4:0] OS_VOTE = 5'(OVERSAMPLE / 2 + 1);
   localparam logic [3:0] DB_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0] SB_LAST = 4'(STOP_BITS - 1);
   localparam bit         HAS_PAR = (PARITY != 0);
   localparam bit         ODD_PAR = (PARITY == 2);

   // ------------------------------------------------------------------------
   // Sample tick generator (free-running)
   // ------------------------------------------------------------------------
   logic [DIV_W-1:0] r_div_cnt;
   logic             w_tick;

   assign w_tick = (r_div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt <= '0;
      end else if (w_tick) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------------
   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PAR,
      TX_STOP
   } tx_state_t;

   tx_state_t              r_tx_state;
   tx_state_t              w_tx_state_nx;
   logic [4:0]             r_tx_os;
   logic [4:0]             w_tx_os_nx;
   logic [3:0]             r_tx_bit;
   logic [3:0]             w_tx_bit_nx;
   logic [DATA_BITS-1:0]   r_tx_shift;
   logic                   r_tx_par;
   logic                   w_tx_load;
   logic                   w_tx_shift;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state <= TX_IDLE;
         r_tx_os    <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_tx_par   <= 1'b0;
      end else begin
         r_tx_state <= w_tx_state_nx;
         r_tx_os    <= w_tx_os_nx;
         r_tx_bit   <= w_tx_bit_nx;
         if (w_tx_load) begin
            r_tx_shift <= tx_data;
            r_tx_par   <= ODD_PAR ? ~^tx_data : ^tx_data;
         end else if (w_tx_shift) begin
            // LSB goes out first, so the next bit moves into position 0
            r_tx_shift <= r_tx_shift >> 1;
         end
      end
   end

   always_comb begin
      w_tx_state_nx = r_tx_state;
      w_tx_os_nx    = r_tx_os;
      w_tx_bit_nx   = r_tx_bit;
      w_tx_load     = 1'b0;
      w_tx_shift    = 1'b0;
      tx            = 1'b1;
      tx_ready      = 1'b0;

      case (r_tx_state)
         TX_IDLE: begin
            tx_ready = 1'b1;
            if (tx_valid) begin
               w_tx_state_nx = TX_START;
               w_tx_os_nx    = '0;
               w_tx_bit_nx   = '0;
               w_tx_load     = 1'b1;
            end
         end
         TX_START: tx = 1'b0;
         TX_DATA:  tx = r_tx_shift[0];
         TX_PAR:   tx = r_tx_par;
         default:  tx = 1'b1;
      endcase

      // A bit period ends on its OVERSAMPLE-th tick
      if (r_tx_state != TX_IDLE && w_tick) begin
         if (r_tx_os == OS_LAST) begin
            w_tx_os_nx = '0;
            case (r_tx_state)
               TX_START: begin
                  w_tx_state_nx = TX_DATA;
                  w_tx_bit_nx   = '0;
               end
               TX_DATA: begin
                  w_tx_shift = 1'b1;
                  if (r_tx_bit == DB_LAST) begin
                     w_tx_state_nx = HAS_PAR ? TX_PAR : TX_STOP;
                     w_tx_bit_nx   = '0;
                  end else begin
                     w_tx_bit_nx = r_tx_bit + 1'b1;
                  end
               end
               TX_PAR: begin
                  w_tx_state_nx = TX_STOP;
                  w_tx_bit_nx   = '0;
               end
               TX_STOP: begin
                  if (r_tx_bit == SB_LAST) begin
                     w_tx_state_nx = TX_IDLE;
                     w_tx_bit_nx   = '0;
                  end else begin
                     w_tx_bit_nx = r_tx_bit + 1'b1;
                  end
               end
               default: w_tx_state_nx = TX_IDLE;
            endcase
         end else begin
            w_tx_os_nx = r_tx_os + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Receiver: synchroniser and edge detect
   // ------------------------------------------------------------------------
   logic r_rx_meta;
   logic r_rx_sync;
   logic r_rx_prev;
   logic w_rx_fall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   assign w_rx_fall = r_rx_prev & ~r_rx_sync;

   // ------------------------------------------------------------------------
   // Receiver FSM
   // ------------------------------------------------------------------------
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PAR,
      RX_STOP
   } rx_state_t;

   rx_state_t              r_rx_state;
   rx_state_t              w_rx_state_nx;
   logic [4:0]             r_rx_os;
   logic [4:0]             w_rx_os_nx;
   logic [3:0]             r_rx_bit;
   logic [3:0]             w_rx_bit_nx;
   logic [1:0]             r_rx_smp;
   logic [DATA_BITS-1:0]   r_rx_shift;
   logic                   r_rx_par;
   logic                   w_vote;
   logic                   w_rx_at_vote;
   logic                   w_rx_done;
   logic                   w_par_exp;
   logic                   w_par_err;

   // The third sample is taken live on the vote tick; the first two are stored
   assign w_vote = (r_rx_smp[1] & r_rx_smp[0]) |
                   (r_rx_smp[1] & r_rx_sync)   |
                   (r_rx_smp[0] & r_rx_sync);
   assign w_rx_at_vote = w_tick && (r_rx_os == OS_VOTE);
   assign w_par_exp    = ODD_PAR ? ~^r_rx_shift : ^r_rx_shift;
   assign w_par_err    = HAS_PAR && (r_rx_par != w_par_exp);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_state <= RX_IDLE;
         r_rx_os    <= '0;
         r_rx_bit   <= '0;
         r_rx_smp   <= 2'b11;
         r_rx_shift <= '0;
         r_rx_par   <= 1'b0;
      end else begin
         r_rx_state <= w_rx_state_nx;
         r_rx_os    <= w_rx_os_nx;
         r_rx_bit   <= w_rx_bit_nx;
         if (r_rx_state != RX_IDLE && w_tick &&
             (r_rx_os == OS_S0 || r_rx_os == OS_S1)) begin
            r_rx_smp <= {r_rx_smp[0], r_rx_sync};
         end
         if (w_rx_at_vote && r_rx_state == RX_DATA) begin
            r_rx_shift <= {w_vote, r_rx_shift[DATA_BITS-1:1]};
         end
         if (w_rx_at_vote && r_rx_state == RX_PAR) begin
            r_rx_par <= w_vote;
         end
      end
   end

   always_comb begin
      w_rx_state_nx = r_rx_state;
      w_rx_os_nx    = r_rx_os;
      w_rx_bit_nx   = r_rx_bit;
      w_rx_done     = 1'b0;

      if (r_rx_state == RX_IDLE) begin
         // Phase 0 is aligned with the detected falling edge
         if (w_rx_fall) begin
            w_rx_state_nx = RX_START;
            w_rx_os_nx    = '0;
            w_rx_bit_nx   = '0;
         end
      end else if (w_tick) begin
         w_rx_os_nx = (r_rx_os == OS_LAST) ? 5'd0 : r_rx_os + 1'b1;

         if (r_rx_os == OS_VOTE) begin
            // A start bit that votes high was a glitch
            if (r_rx_state == RX_START && w_vote) begin
               w_rx_state_nx = RX_IDLE;
            end
            // Frame ends at the first stop-bit vote so the next start edge is
            // caught even with a short stop bit
            if (r_rx_state == RX_STOP) begin
               w_rx_state_nx = RX_IDLE;
               w_rx_done     = 1'b1;
            end
         end

         if (r_rx_os == OS_LAST) begin
            case (r_rx_state)
               RX_START: begin
                  w_rx_state_nx = RX_DATA;
                  w_rx_bit_nx   = '0;
               end
               RX_DATA: begin
                  if (r_rx_bit == DB_LAST) begin
                     w_rx_state_nx = HAS_PAR ? RX_PAR : RX_STOP;
                     w_rx_bit_nx   = '0;
                  end else begin
                     w_rx_bit_nx = r_rx_bit + 1'b1;
                  end
               end
               RX_PAR:  w_rx_state_nx = RX_STOP;
               default: ;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // Receive output holding register
   // ------------------------------------------------------------------------
   logic                 r_rx_valid;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_ferr;
   logic                 r_rx_perr;
   logic                 r_rx_ovr;
   logic                 w_accept;

   assign w_accept = r_rx_valid & rx_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_valid <= 1'b0;
         r_rx_data  <= '0;
         r_rx_ferr  <= 1'b0;
         r_rx_perr  <= 1'b0;
         r_rx_ovr   <= 1'b0;
      end else if (w_rx_done && (!r_rx_valid || w_accept)) begin
         // A simultaneous accept frees the slot for the new frame
         r_rx_valid <= 1'b1;
         r_rx_data  <= r_rx_shift;
         r_rx_ferr  <= ~w_vote;
         r_rx_perr  <= w_par_err;
         r_rx_ovr   <= 1'b0;
      end else if (w_rx_done) begin
         r_rx_ovr <= 1'b1;
      end else if (w_accept) begin
         r_rx_valid <= 1'b0;
         r_rx_data  <= '0;
         r_rx_ferr  <= 1'b0;
         r_rx_perr  <= 1'b0;
         r_rx_ovr   <= 1'b0;
      end
   end

   assign rx_valid      = r_rx_valid;
   assign rx_data       = r_rx_data;
   assign rx_frame_err  = r_rx_ferr;
   assign rx_parity_err = r_rx_perr;
   assign rx_overrun    = r_rx_ovr;

endmodule

// File: tb/tb_uart_core.sv
// ---------------------------------------------------------------------------
// tb_uart_core
//   Bench for uart_core. It uses two instances, both at 16 clocks per bit:
//     dut_a: 8 data bits, even parity, 1 stop bit (TX, RX, glitch, overrun,
//            reset)
//     dut_b: 7 data bits, odd parity, 2 stop bits, with tx looped to rx
//   Expected frames come from frame_vec(). It builds the line bit sequence
//   from the payload with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_uart_core;

   localparam int BITCLK = 16;

   logic clk;
   logic rst;

   logic       a_tx_valid, a_tx_ready, a_tx, a_rx, a_rx_valid, a_rx_ready;
   logic [7:0] a_tx_data, a_rx_data;
   logic       a_ferr, a_perr, a_ovr;

   logic       b_tx_valid, b_tx_ready, b_tx, b_rx, b_rx_valid, b_rx_ready;
   logic [6:0] b_tx_data, b_rx_data;
   logic       b_ferr, b_perr, b_ovr;

   int total;
   int bad;

   uart_core #(
      .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
      .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)
   ) dut_a (
      .clk(clk), .rst(rst),
      .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_ready(a_tx_ready), .tx(a_tx),
      .rx(a_rx), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_data(a_rx_data),
      .rx_frame_err(a_ferr), .rx_parity_err(a_perr), .rx_overrun(a_ovr)
   );

   uart_core #(
      .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
      .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
   ) dut_b (
      .clk(clk), .rst(rst),
      .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(b_tx_ready), .tx(b_tx),
      .rx(b_rx), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_data(b_rx_data),
      .rx_frame_err(b_ferr), .rx_parity_err(b_perr), .rx_overrun(b_ovr)
   );

   assign b_rx = b_tx;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // Line bit k of a frame is bit k of the result; n returns the frame length
   function automatic logic [15:0] frame_vec(input int d, input int db, input int par,
                                             input int nstop, input bit bad_stop,
                                             input bit bad_par, output int n);
      logic [15:0] v;
      int          p;
      int          ones;
      v    = '1;
      p    = 0;
      v[p] = 1'b0;
      p++;
      for (int i = 0; i < db; i++) begin
         v[p] = 1'((d >> i) & 1);
         p++;
      end
      ones = $countones(d & ((1 << db) - 1));
      if (par != 0) begin
         v[p] = 1'((par == 1) ? (ones % 2) : ((ones + 1) % 2)) ^ bad_par;
         p++;
      end
      for (int s = 0; s < nstop; s++) begin
         v[p] = (s == 0) ? ~bad_stop : 1'b1;
         p++;
      end
      n = p;
      return v;
   endfunction

   task automatic send_rx_a(input logic [15:0] v, input int n);
      for (int k = 0; k < n; k++) begin
         a_rx = v[k];
         repeat (BITCLK) @(posedge clk);
         #1;
      end
      a_rx = 1'b1;
   endtask

   task automatic test_reset;
      total++; if (a_tx !== 1'b1) begin bad++; $display("FAIL reset_a_tx got=%b exp=1", a_tx); end
      total++; if (a_tx_ready !== 1'b1) begin bad++; $display("FAIL reset_a_tx_ready got=%b exp=1", a_tx_ready); end
      total++; if (a_rx_valid !== 1'b0) begin bad++; $display("FAIL reset_a_rx_valid got=%b exp=0", a_rx_valid); end
      total++; if (a_rx_data !== 8'h00) begin bad++; $display("FAIL reset_a_rx_data got=%h exp=00", a_rx_data); end
      total++; if ({a_ferr, a_perr, a_ovr} !== 3'b000) begin bad++; $display("FAIL reset_a_flags got=%b exp=000", {a_ferr, a_perr, a_ovr}); end
      total++; if (b_tx !== 1'b1 || b_tx_ready !== 1'b1) begin bad++; $display("FAIL reset_b_tx got=%b/%b exp=1/1", b_tx, b_tx_ready); end
      total++; if ({b_rx_valid, b_rx_data, b_ferr, b_perr, b_ovr} !== 11'd0) begin bad++; $display("FAIL reset_b_rx got=%b exp=0", {b_rx_valid, b_rx_data, b_ferr, b_perr, b_ovr}); end
   endtask

   task automatic test_tx_a(input logic [7:0] d);
      logic [15:0] fv;
      int          n;
      fv = frame_vec(int'(d), 8, 1, 1, 1'b0, 1'b0, n);
      @(posedge clk); #1;
      a_tx_valid = 1'b1;
      a_tx_data  = d;
      @(posedge clk); #1;
      a_tx_valid = 1'b0;
      for (int k = 0; k < n * BITCLK; k++) begin
         total++;
         if (a_tx !== fv[k / BITCLK] || a_tx_ready !== 1'b0) begin
            bad++;
            $display("FAIL tx_bit data=%h clk=%0d got tx=%b ready=%b exp tx=%b ready=0",
                     d, k, a_tx, a_tx_ready, fv[k / BITCLK]);
         end
         @(posedge clk); #1;
      end
      total++;
      if (a_tx_ready !== 1'b1 || a_tx !== 1'b1) begin
         bad++;
         $display("FAIL tx_end data=%h got tx=%b ready=%b exp 1/1", d, a_tx, a_tx_ready);
      end
   endtask

   task automatic test_loopback_b(input logic [6:0] d);
      bit got;
      @(posedge clk); #1;
      b_tx_valid = 1'b1;
      b_tx_data  = d;
      @(posedge clk); #1;
      b_tx_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
         if (b_rx_valid === 1'b1) got = 1'b1;
         else begin @(posedge clk); #1; end
      end
      total++; if (!got) begin bad++; $display("FAIL loop_timeout data=%h got rx_valid=0 exp 1", d); end
      total++; if (b_rx_data !== d) begin bad++; $display("FAIL loop_data got=%h exp=%h", b_rx_data, d); end
      total++; if ({b_ferr, b_perr, b_ovr} !== 3'b000) begin bad++; $display("FAIL loop_flags data=%h got=%b exp=000", d, {b_ferr, b_perr, b_ovr}); end
      b_rx_ready = 1'b1;
      @(posedge clk); #1;
      b_rx_ready = 1'b0;
      total++; if (b_rx_valid !== 1'b0) begin bad++; $display("FAIL loop_accept got rx_valid=%b exp 0", b_rx_valid); end
      got = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
         if (b_tx_ready === 1'b1) got = 1'b1;
         else begin @(posedge clk); #1; end
      end
      total++; if (!got) begin bad++; $display("FAIL loop_tx_ready got=0 exp=1"); end
   endtask

   task automatic test_rx_a(input logic [7:0] d, input bit bad_stop, input bit bad_par);
      logic [15:0] fv;
      int          n;
      bit          got;
      fv = frame_vec(int'(d), 8, 1, 1, bad_stop, bad_par, n);
      a_rx_ready = 1'b0;
      send_rx_a(fv, n);
      got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
         if (a_rx_valid === 1'b1) got = 1'b1;
         else begin @(posedge clk); #1; end
      end
      total++; if (!got) begin bad++; $display("FAIL rx_timeout data=%h got rx_valid=0 exp 1", d); end
      total++; if (a_rx_data !== d) begin bad++; $display("FAIL rx_data got=%h exp=%h", a_rx_data, d); end
      total++; if (a_ferr !== bad_stop) begin bad++; $display("FAIL rx_frame_err data=%h got=%b exp=%b", d, a_ferr, bad_stop); end
      total++; if (a_perr !== bad_par) begin bad++; $display("FAIL rx_parity_err data=%h got=%b exp=%b", d, a_perr, bad_par); end
      total++; if (a_ovr !== 1'b0) begin bad++; $display("FAIL rx_overrun data=%h got=%b exp=0", d, a_ovr); end
      repeat (3) @(posedge clk);
      #1;
      total++; if (a_rx_valid !== 1'b1 || a_rx_data !== d) begin bad++; $display("FAIL rx_hold got v=%b d=%h exp v=1 d=%h", a_rx_valid, a_rx_data, d); end
      a_rx_ready = 1'b1;
      @(posedge clk); #1;
      a_rx_ready = 1'b0;
      total++;
      if ({a_rx_valid, a_rx_data, a_ferr, a_perr, a_ovr} !== 12'd0) begin
         bad++;
         $display("FAIL rx_accept got v=%b d=%h f=%b p=%b o=%b exp all 0", a_rx_valid, a_rx_data, a_ferr, a_perr, a_ovr);
      end
      repeat (BITCLK) @(posedge clk);
      #1;
   endtask

   task automatic test_glitch;
      bit seen;
      @(posedge clk); #1;
      a_rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      a_rx = 1'b1;
      seen = 1'b0;
      repeat (300) begin
         @(posedge clk); #1;
         if (a_rx_valid !== 1'b0) seen = 1'b1;
      end
      total++; if (seen) begin bad++; $display("FAIL glitch got rx_valid=1 exp 0"); end
      test_rx_a(8'($urandom_range(0, 255)), 1'b0, 1'b0);
   endtask

   task automatic test_overrun;
      logic [15:0] f1;
      logic [15:0] f2;
      int          n;
      a_rx_ready = 1'b0;
      f1 = frame_vec(32'h11, 8, 1, 1, 1'b0, 1'b0, n);
      send_rx_a(f1, n);
      f2 = frame_vec(32'h22, 8, 1, 1, 1'b0, 1'b0, n);
      send_rx_a(f2, n);
      repeat (5) @(posedge clk);
      #1;
      total++; if (a_rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", a_rx_valid); end
      total++; if (a_rx_data !== 8'h11) begin bad++; $display("FAIL ovr_data got=%h exp=11", a_rx_data); end
      total++; if (a_ovr !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", a_ovr); end
      total++; if ({a_ferr, a_perr} !== 2'b00) begin bad++; $display("FAIL ovr_errs got=%b exp=00", {a_ferr, a_perr}); end
      a_rx_ready = 1'b1;
      @(posedge clk); #1;
      a_rx_ready = 1'b0;
      total++;
      if (a_rx_valid !== 1'b0 || a_ovr !== 1'b0 || a_rx_data !== 8'h00) begin
         bad++;
         $display("FAIL ovr_accept got v=%b o=%b d=%h exp 0/0/00", a_rx_valid, a_ovr, a_rx_data);
      end
   endtask

   task automatic test_reset_mid_tx;
      logic [15:0] fv;
      int          n;
      logic [7:0]  d;
      bit          got;
      a_rx_ready = 1'b0;
      fv = frame_vec(32'h5A, 8, 1, 1, 1'b1, 1'b1, n);
      send_rx_a(fv, n);
      got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
         if (a_rx_valid === 1'b1) got = 1'b1;
         else begin @(posedge clk); #1; end
      end
      total++;
      if (!got || {a_rx_data, a_ferr, a_perr} !== {8'h5A, 2'b11}) begin
         bad++;
         $display("FAIL prereset_rx got v=%b d=%h f=%b p=%b exp 1/5a/1/1", a_rx_valid, a_rx_data, a_ferr, a_perr);
      end
      d = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      a_tx_valid = 1'b1;
      a_tx_data  = d;
      @(posedge clk); #1;
      a_tx_valid = 1'b0;
      repeat (BITCLK * 4 + 6) @(posedge clk);
      #1;
      total++; if (a_tx !== d[3] || a_tx_ready !== 1'b0) begin bad++; $display("FAIL midtx_bit3 got tx=%b ready=%b exp tx=%b ready=0", a_tx, a_tx_ready, d[3]); end
      rst = 1'b1;
      @(posedge clk); #1;
      total++; if (a_tx !== 1'b1 || a_tx_ready !== 1'b1) begin bad++; $display("FAIL rst_tx got tx=%b ready=%b exp 1/1", a_tx, a_tx_ready); end
      total++;
      if ({a_rx_valid, a_rx_data, a_ferr, a_perr, a_ovr} !== 12'd0) begin
         bad++;
         $display("FAIL rst_rx got v=%b d=%h f=%b p=%b o=%b exp all 0", a_rx_valid, a_rx_data, a_ferr, a_perr, a_ovr);
      end
      rst = 1'b0;
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst        = 1'b1;
      a_tx_valid = 1'b0;
      a_tx_data  = '0;
      a_rx       = 1'b1;
      a_rx_ready = 1'b0;
      b_tx_valid = 1'b0;
      b_tx_data  = '0;
      b_rx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;

      test_tx_a(8'hA5);
      repeat (3) test_tx_a(8'($urandom_range(0, 255)));

      test_loopback_b(7'h3C);
      repeat (3) test_loopback_b(7'($urandom_range(0, 127)));

      test_rx_a(8'h55, 1'b1, 1'b0);
      repeat (4) test_rx_a(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));

      test_glitch();
      test_overrun();
      test_reset_mid_tx();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
